// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-ROM, redirect and decode-handshake signals of the fetch unit
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [ADDR_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_instr;
  modport master (
    output imem_addr, out_valid, out_pc, out_instr,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch PC, prefetch FIFO and redirect flush; IFU_PERF_CNT_EN adds a push counter
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2,
  parameter int                    PC_STEP    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en_i,
  instruction_fetch_unit_if.master   bus,
  output logic [31:0]                fetch_count_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {S_IDLE, S_RUN} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic                  push, pop;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = count_q != '0;
  assign bus.out_pc    = pc_mem_q[rd_ptr_q];
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign pop  = bus.out_valid && bus.out_ready;
  assign push = state_q == S_RUN && fetch_en_i && !bus.redirect_valid &&
                (count_q < CW'(FIFO_DEPTH) || pop);
  // Run/idle control: fetching is allowed only while enabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= fetch_en_i ? S_RUN : S_IDLE;
  // Next PC and FIFO bookkeeping; a redirect discards everything and wins over push/pop
  always_comb begin
    fetch_pc_d = bus.redirect_valid ? bus.redirect_pc & ~ADDR_WIDTH'(3) :
                 push ? fetch_pc_q + ADDR_WIDTH'(PC_STEP) : fetch_pc_q;
    wr_ptr_d   = bus.redirect_valid ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d   = bus.redirect_valid ? '0 : rd_ptr_q + PW'(pop);
    count_d    = bus.redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // PC, pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  // Entry storage; cleared on reset so the head reads as zero until the first fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= bus.imem_data;
    end
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  // Push counter, survives redirects
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    fetch_count_q <= '0;
    else if (push) fetch_count_q <= fetch_count_q + 32'd1;
  assign fetch_count_o = fetch_count_q;
`else
  assign fetch_count_o = '0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: queue-model scoreboard plus directed literal checks for the fetch unit
module tb_instruction_fetch_unit;
  logic clk = 0, rst_n = 0, fetch_en = 0;
  logic [31:0] fc1, fc2;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  instruction_fetch_unit_if #(32, 32) b1 ();
  instruction_fetch_unit_if #(32, 32) b2 ();
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction
  assign b1.imem_data = rom(b1.imem_addr);
  assign b2.imem_data = rom(b2.imem_addr);
  assign b2.redirect_valid = 1'b0;
  assign b2.redirect_pc = '0;
  assign b2.out_ready = 1'b1;
  instruction_fetch_unit dut (.clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .bus(b1), .fetch_count_o(fc1));
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (.clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .bus(b2), .fetch_count_o(fc2));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: a queue of {pc, instr} entries with at most two elements
  logic [63:0] q[$];
  logic [31:0] m_pc, m_cnt;
  logic m_run, m_pop;
  int m_n;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      m_pc = 0;
      m_cnt = 0;
      m_run = 0;
    end else begin
      m_pop = q.size() != 0 && b1.out_ready;
      m_n = q.size();
      if (b1.redirect_valid) begin
        q.delete();
        m_pc = b1.redirect_pc & ~32'h3;
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_run && fetch_en && (m_n < 2 || m_pop)) begin
          q.push_back({m_pc, rom(m_pc)});
          m_pc = m_pc + 4;
          m_cnt = m_cnt + 1;
        end
      end
      m_run = fetch_en;
    end
  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    chk("imem_addr", b1.imem_addr, m_pc);
    chk("out_valid", b1.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_pc", b1.out_pc, q[0][63:32]);
      chk("out_instr", b1.out_instr, q[0][31:0]);
    end
`ifdef IFU_PERF_CNT_EN
    chk("fetch_count", fc1, m_cnt);
`else
    chk("fetch_count", fc1, 0);
`endif
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  initial begin
    b1.redirect_valid = 0;
    b1.redirect_pc = 0;
    b1.out_ready = 0;
    tick(2);
    chk("rst_valid", b1.out_valid, 0);
    chk("rst_pc", b1.out_pc, 0);
    chk("rst_instr", b1.out_instr, 0);
    chk("rst_addr", b1.imem_addr, 0);
    chk("rst_count", fc1, 0);
    chk("rst_addr2", b2.imem_addr, 32'hFFFF_FFF8);
    rst_n = 1;
    fetch_en = 1;
    b1.out_ready = 1;
    tick(2);
    chk("first_valid", b1.out_valid, 1);
    chk("first_pc", b1.out_pc, 0);
    chk("first_instr", b1.out_instr, 32'h1000);
    chk("wrap_pc0", b2.out_pc, 32'hFFFF_FFF8);
    tick();
    chk("second_pc", b1.out_pc, 4);
    chk("second_instr", b1.out_instr, 32'h1001);
    chk("wrap_pc1", b2.out_pc, 32'hFFFF_FFFC);
    tick();
    chk("third_pc", b1.out_pc, 8);
    chk("wrap_pc2", b2.out_pc, 32'h0);
    tick(7);
    b1.redirect_valid = 1;
    b1.redirect_pc = 32'h100;
    tick();
    b1.redirect_valid = 0;
    chk("redir_valid", b1.out_valid, 0);
    chk("redir_addr", b1.imem_addr, 32'h100);
    tick();
    chk("redir_pc", b1.out_pc, 32'h100);
    tick(2);
    fetch_en = 0;
    tick();
`ifdef IFU_PERF_CNT_EN
    chk("perf_13", fc1, 13);
`else
    chk("perf_off", fc1, 0);
`endif
    fetch_en = 1;
    b1.out_ready = 0;
    b1.redirect_valid = 1;
    b1.redirect_pc = 32'h0;
    tick();
    b1.redirect_valid = 0;
    tick(5);
    chk("full_valid", b1.out_valid, 1);
    chk("full_pc", b1.out_pc, 0);
    chk("full_instr", b1.out_instr, 32'h1000);
    chk("full_addr", b1.imem_addr, 8);
    b1.out_ready = 1;
    tick();
    chk("drain_pc4", b1.out_pc, 4);
    tick();
    chk("drain_pc8", b1.out_pc, 8);
    b1.out_ready = 0;
    tick();
    b1.redirect_valid = 1;
    b1.redirect_pc = 32'h43;
    tick();
    b1.redirect_valid = 0;
    chk("flush_valid", b1.out_valid, 0);
    chk("flush_addr", b1.imem_addr, 32'h40);
    b1.out_ready = 1;
    tick();
    chk("flush_pc", b1.out_pc, 32'h40);
    chk("flush_instr", b1.out_instr, 32'h1010);
    b1.out_ready = 0;
    tick(2);
    fetch_en = 0;
    b1.out_ready = 1;
    tick(3);
    chk("pause_valid", b1.out_valid, 0);
    chk("pause_addr", b1.imem_addr, 32'h48);
    fetch_en = 1;
    tick(2);
    chk("resume_pc", b1.out_pc, 32'h48);
    chk("resume_instr", b1.out_instr, 32'h1012);
    tick(3);
    rst_n = 0;
    #1;
    chk("arst_valid", b1.out_valid, 0);
    chk("arst_pc", b1.out_pc, 0);
    chk("arst_instr", b1.out_instr, 0);
    chk("arst_addr", b1.imem_addr, 0);
    chk("arst_count", fc1, 0);
    tick();
    rst_n = 1;
    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. It owns the fetch PC, drives the address into the combinational instruction ROM, and captures the returned word. Fetched {pc, instruction} pairs are buffered in a small prefetch FIFO and handed to decode over a valid/ready handshake. Branch/jump redirects from execute flush the FIFO and restart fetch at the target.

Parameters:
ADDR_WIDTH, 32, width of fetch PC and imem_addr
DATA_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, fetch PC after reset (low 2 bits must be 0)
FIFO_DEPTH, 2, prefetch entries; power of 2, at least 2
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  allow new fetches; when 0, FIFO still drains
imem_addr  output  ADDR_WIDTH  address to instruction ROM (combinational = fetch_pc)
imem_data  input  DATA_WIDTH  ROM read data for imem_addr, valid same cycle
redirect_valid  input  1  flush and restart at redirect_pc
redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] ignored (forced 0)
out_valid  output  1  FIFO head valid
out_ready  input  1  decode accepts head
out_pc  output  ADDR_WIDTH  PC of head instruction
out_instr  output  DATA_WIDTH  head instruction
fetch_count  output  32  number of words pushed (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC; FIFO empty (rd/wr ptr=0, count=0); out_valid=0; out_pc=0; out_instr=0; fetch_count=0; state=S_IDLE.
- FSM: S_IDLE -> S_RUN when fetch_en=1. S_RUN -> S_IDLE when fetch_en=0. No push in S_IDLE. redirect_valid is honoured in both states (state unchanged).
- imem_addr = fetch_pc at all times; ROM is combinational, so push data is imem_data sampled at the clock edge.
- push = (state==S_RUN) && !redirect_valid && (count<FIFO_DEPTH || pop).
- pop = out_valid && out_ready.
- On push: write {fetch_pc, imem_data} at wr_ptr; fetch_pc += PC_STEP, wrapping mod 2^ADDR_WIDTH (0xFFFF_FFFC -> 0x0000_0000).
- Full FIFO with simultaneous pop: push allowed, count unchanged.
- Empty FIFO: pop is impossible since out_valid=0. There is no bypass, so minimum fetch-to-out_valid latency is 1 cycle.
- Redirect (highest priority): on the edge where redirect_valid=1, set count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[ADDR_WIDTH-1:2],2'b00}. No push and no count change that cycle. A pop handshake in the same cycle is still considered accepted by decode, but the FIFO is discarded regardless.
- out_valid = (count!=0). out_pc and out_instr come from the head entry, registered storage. They hold stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- fetch_en deasserted mid-operation: the current cycle's push is suppressed, fetch_pc holds, and buffered entries remain poppable.
- Reset asserted mid-operation: immediate return to reset values; no partial entries survive.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: fetch_count increments by 1 on every push, wrapping at 2^32. It is cleared by reset only, not by redirect.
- Undefined: fetch_count is tied to 0 and no counter logic is generated.

Test Plan:
- Reset then fetch_en=1, out_ready=1, ROM[i]=0x1000+i -> out_valid rises 1 cycle after the first push; out_pc=0,4,8... with out_instr=0x1000,0x1001,... one per cycle.
- out_ready=0 for 5 cycles -> FIFO fills at 2 entries, fetch_pc holds at 0x8, imem_addr=0x8, head stays pc=0/instr=0x1000. Release out_ready -> in-order delivery with no gap or duplicate.
- Redirect to 0x0000_0043 while FIFO is full -> next cycle out_valid=0, imem_addr=0x40. The first delivered entry afterwards is pc=0x40; no stale entries appear.
- RESET_PC=0xFFFF_FFF8, run 3 fetches -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- fetch_en pulsed low 3 cycles with out_ready=1 -> 2 queued entries drain, out_valid drops, pc resumes with no skipped address; rst_n asserted mid-stream -> outputs return to 0 asynchronously.
- With IFU_PERF_CNT_EN, 10 pushes, a redirect, then 3 more pushes -> fetch_count=13. Without the macro -> fetch_count=0 throughout.
